// File: rtl/adder_pkg.sv
// Shared definitions for the pipelined adder/subtractor: op encoding and the
// slice-width helper used to size each carry slice.
package adder_pkg;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  function automatic int slice_w(input int width, input int stages);
    return width / stages;
  endfunction

endpackage

// File: rtl/adder_slice.sv
// One registered carry slice: sum/cout of a + b + cin, latency 1.
// i_en low freezes every register; i_clr (synchronous) wins over i_en.
module adder_slice #(
  parameter int CW = 16
) (
  input  logic          i_clk,
  input  logic          i_clr,
  input  logic          i_en,
  input  logic [CW-1:0] i_a,
  input  logic [CW-1:0] i_b,
  input  logic          i_cin,
  output logic [CW-1:0] o_sum,
  output logic          o_cout,
  output logic          o_a_msb,
  output logic          o_b_msb
);

  logic [CW:0]   w_full;
  logic [CW-1:0] r_sum;
  logic          r_cout;
  logic          r_a_msb;
  logic          r_b_msb;

  assign w_full = {1'b0, i_a} + {1'b0, i_b} + {{CW{1'b0}}, i_cin};

  // Operand MSBs travel with the sum so the top slice can form signed overflow.
  always_ff @(posedge i_clk) begin
    if (i_clr) begin
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_a_msb <= 1'b0;
      r_b_msb <= 1'b0;
    end else if (i_en) begin
      r_sum   <= w_full[CW-1:0];
      r_cout  <= w_full[CW];
      r_a_msb <= i_a[CW-1];
      r_b_msb <= i_b[CW-1];
    end
  end

  assign o_sum   = r_sum;
  assign o_cout  = r_cout;
  assign o_a_msb = r_a_msb;
  assign o_b_msb = r_b_msb;

endmodule

// File: rtl/pipe_adder.sv
// Pipelined WIDTH-bit add/sub split into STAGES carry slices; latency STAGES, one op/cycle.
// No backpressure output: hold_i freezes everything, flush_i drops in-flight valids.
module pipe_adder
  import adder_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             valid_i,
  input  logic             op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             hold_i,
  input  logic             flush_i,
  output logic [WIDTH-1:0] sum_o,
  output logic             carry_o,
  output logic             ovf_o,
  output logic             valid_o
);

  localparam int CW = slice_w(WIDTH, STAGES);

  logic [WIDTH-1:0] w_b_eff;
  logic             w_en;
  logic             w_clr;
  logic             w_cout [STAGES];
  logic             w_top_a_msb;
  logic             w_top_b_msb;
  logic             r_op;
  logic [STAGES:0]  r_vld;

  assign w_en    = !hold_i;
  assign w_clr   = !Rst_n;
  assign w_b_eff = (op_i == OP_SUB) ? ~b_i : b_i;

  // r_vld[0] marks the capture registers; r_vld[STAGES] is the output valid.
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      r_vld <= '0;
      r_op  <= 1'b0;
    end else begin
      if (flush_i) begin
        r_vld <= '0;
      end else if (!hold_i) begin
        r_vld <= {r_vld[STAGES-1:0], valid_i};
      end
      if (!hold_i) begin
        r_op <= op_i;
      end
    end
  end

  for (genvar gk = 0; gk < STAGES; gk++) begin : g_sl
    localparam int DLY_OUT = STAGES - 1 - gk;

    logic [CW-1:0] r_a_d [gk+1];
    logic [CW-1:0] r_b_d [gk+1];
    logic [CW-1:0] w_sum;
    logic          w_cin;

    // Element 0 is the capture register; slice gk reads its operands gk cycles later.
    always_ff @(posedge Clk) begin
      if (!Rst_n) begin
        for (int j = 0; j <= gk; j++) begin
          r_a_d[j] <= '0;
          r_b_d[j] <= '0;
        end
      end else if (!hold_i) begin
        r_a_d[0] <= a_i[gk*CW +: CW];
        r_b_d[0] <= w_b_eff[gk*CW +: CW];
        for (int j = 1; j <= gk; j++) begin
          r_a_d[j] <= r_a_d[j-1];
          r_b_d[j] <= r_b_d[j-1];
        end
      end
    end

    if (gk == 0) begin : g_cin0
      assign w_cin = r_op;
    end else begin : g_cinn
      assign w_cin = w_cout[gk-1];
    end

    if (gk == STAGES - 1) begin : g_top
      adder_slice #(.CW(CW)) u_slice (
        .i_clk   (Clk),
        .i_clr   (w_clr),
        .i_en    (w_en),
        .i_a     (r_a_d[gk]),
        .i_b     (r_b_d[gk]),
        .i_cin   (w_cin),
        .o_sum   (w_sum),
        .o_cout  (w_cout[gk]),
        .o_a_msb (w_top_a_msb),
        .o_b_msb (w_top_b_msb)
      );
    end else begin : g_low
      logic w_a_msb_unused;
      logic w_b_msb_unused;
      adder_slice #(.CW(CW)) u_slice (
        .i_clk   (Clk),
        .i_clr   (w_clr),
        .i_en    (w_en),
        .i_a     (r_a_d[gk]),
        .i_b     (r_b_d[gk]),
        .i_cin   (w_cin),
        .o_sum   (w_sum),
        .o_cout  (w_cout[gk]),
        .o_a_msb (w_a_msb_unused),
        .o_b_msb (w_b_msb_unused)
      );
    end

    // Lower slices finish early and wait here so all slices leave together.
    if (DLY_OUT > 0) begin : g_dly
      logic [CW-1:0] r_s_d [DLY_OUT];
      always_ff @(posedge Clk) begin
        if (!Rst_n) begin
          for (int j = 0; j < DLY_OUT; j++) begin
            r_s_d[j] <= '0;
          end
        end else if (!hold_i) begin
          r_s_d[0] <= w_sum;
          for (int j = 1; j < DLY_OUT; j++) begin
            r_s_d[j] <= r_s_d[j-1];
          end
        end
      end
      assign sum_o[gk*CW +: CW] = r_s_d[DLY_OUT-1];
    end else begin : g_nodly
      assign sum_o[gk*CW +: CW] = w_sum;
    end
  end

  assign carry_o = w_cout[STAGES-1];
  assign ovf_o   = (w_top_a_msb == w_top_b_msb) && (sum_o[WIDTH-1] != w_top_a_msb);
  assign valid_o = r_vld[STAGES];

endmodule

// File: tb/tb_pipe_adder.sv
// Scoreboard bench for pipe_adder (WIDTH=32, STAGES=2): driver pushes expected
// results, an independent negedge monitor pops and compares.
module tb_pipe_adder;

  localparam int WIDTH  = 32;
  localparam int STAGES = 2;

  typedef struct {
    logic [WIDTH-1:0] s;
    logic             c;
    logic             o;
    int               due;
  } exp_t;

  logic             Clk = 1'b0;
  logic             Rst_n = 1'b0;
  logic             valid_i = 1'b0;
  logic             op_i = 1'b0;
  logic [WIDTH-1:0] a_i = '0;
  logic [WIDTH-1:0] b_i = '0;
  logic             hold_i = 1'b0;
  logic             flush_i = 1'b0;
  logic [WIDTH-1:0] sum_o;
  logic             carry_o;
  logic             ovf_o;
  logic             valid_o;

  int   total = 0;
  int   bad = 0;
  int   adv = 0;
  int   n_pops = 0;
  exp_t q[$];
  exp_t show;
  logic show_vld = 1'b0;
  logic last_rst = 1'b1;
  logic last_hold = 1'b0;
  logic last_flush = 1'b0;

  pipe_adder #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
    .Clk     (Clk),
    .Rst_n   (Rst_n),
    .valid_i (valid_i),
    .op_i    (op_i),
    .a_i     (a_i),
    .b_i     (b_i),
    .hold_i  (hold_i),
    .flush_i (flush_i),
    .sum_o   (sum_o),
    .carry_o (carry_o),
    .ovf_o   (ovf_o),
    .valid_o (valid_o)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference: plain arithmetic on unsigned and signed interpretations.
  function automatic exp_t model(input logic op, input logic [WIDTH-1:0] a,
                                 input logic [WIDTH-1:0] b, input int due);
    exp_t        e;
    logic [32:0] wide;
    longint      sa;
    longint      sb;
    longint      r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    wide = {1'b0, a} + {1'b0, b};
    if (op) begin
      e.s = a - b;
      e.c = (a >= b);
      r   = sa - sb;
    end else begin
      e.s = a + b;
      e.c = wide[32];
      r   = sa + sb;
    end
    e.o   = (r > 64'sd2147483647) || (r < -64'sd2147483648);
    e.due = due;
    return e;
  endfunction

  // Apply one cycle of inputs, then record what that edge means to the model.
  task automatic step(input logic v, input logic op, input logic [WIDTH-1:0] a,
                      input logic [WIDTH-1:0] b, input logic h, input logic f,
                      input logic rn);
    valid_i = v; op_i = op; a_i = a; b_i = b;
    hold_i = h; flush_i = f; Rst_n = rn;
    @(posedge Clk);
    last_rst   = !rn;
    last_hold  = h;
    last_flush = f;
    if (!rn || f) begin
      q.delete();
      show_vld = 1'b0;
    end else if (!h) begin
      adv++;
      if (v) q.push_back(model(op, a, b, adv + STAGES));
    end
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic issue(input logic op, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    step(1'b1, op, a, b, 1'b0, 1'b0, 1'b1);
  endtask

  function automatic logic [WIDTH-1:0] rnd_opnd();
    logic [WIDTH-1:0] corners [7];
    corners = '{32'h0, 32'h1, 32'h7FFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF,
                32'h0000_FFFF, 32'h0001_0000};
    if ($urandom_range(3) == 0) return corners[$urandom_range(6)];
    return $urandom;
  endfunction

  always @(negedge Clk) begin
    exp_t e;
    logic exp_v;
    if (last_rst) begin
      chk("reset_outputs", {31'b0, valid_o, carry_o, ovf_o, sum_o}, 64'h0);
    end else if (last_hold && !last_flush) begin
      chk("hold_valid_frozen", {63'b0, valid_o}, {63'b0, show_vld});
      if (show_vld && valid_o)
        chk("hold_data_frozen", {31'b0, carry_o, ovf_o, sum_o}, {31'b0, show.c, show.o, show.s});
    end else begin
      exp_v = (q.size() > 0) && (q[0].due == adv);
      chk("valid_o", {63'b0, valid_o}, {63'b0, exp_v});
      if (exp_v) begin
        e = q.pop_front();
        n_pops++;
        if (valid_o) begin
          chk("sum_o", {32'b0, sum_o}, {32'b0, e.s});
          chk("carry_o", {63'b0, carry_o}, {63'b0, e.c});
          chk("ovf_o", {63'b0, ovf_o}, {63'b0, e.o});
        end
        show = e;
      end
      show_vld = exp_v;
    end
  end

  initial begin
    int p0;
    step(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 32'h5, 32'h7, 1'b0, 1'b0, 1'b0);
    idle(2);

    // Directed arithmetic corners, streamed back to back.
    issue(1'b0, 32'h0000_FFFF, 32'h0000_0001);
    issue(1'b0, 32'h7FFF_FFFF, 32'h0000_0001);
    issue(1'b0, 32'hFFFF_FFFF, 32'h0000_0001);
    issue(1'b1, 32'h0000_0005, 32'h0000_0007);
    issue(1'b1, 32'h0000_0007, 32'h0000_0005);
    issue(1'b1, 32'h8000_0000, 32'h0000_0001);
    idle(4);

    // A result already on the outputs must stay there through a hold.
    issue(1'b0, 32'h0000_1234, 32'h0000_0001);
    idle(2);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 32'hDEAD, 32'hBEEF, 1'b1, 1'b0, 1'b1);
    idle(3);

    // Streaming with a two-cycle hold after the second issue.
    p0 = n_pops;
    issue(1'b0, 32'd1, 32'd1);
    issue(1'b0, 32'd2, 32'd2);
    step(1'b1, 1'b0, 32'd9, 32'd9, 1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b0, 32'd9, 32'd9, 1'b1, 1'b0, 1'b1);
    issue(1'b0, 32'd3, 32'd3);
    idle(4);
    chk("stream_result_count", 64'(n_pops - p0), 64'd3);

    // Flush together with hold: both the in-flight op and the new one vanish.
    p0 = n_pops;
    issue(1'b0, 32'h10, 32'h10);
    step(1'b1, 1'b0, 32'h20, 32'h20, 1'b1, 1'b1, 1'b1);
    idle(4);
    chk("flush_no_results", 64'(n_pops - p0), 64'd0);
    issue(1'b0, 32'h30, 32'h1);
    idle(3);
    chk("after_flush_result", 64'(n_pops - p0), 64'd1);

    // Reset in the middle of two in-flight ops.
    p0 = n_pops;
    issue(1'b0, 32'h100, 32'h1);
    issue(1'b1, 32'h200, 32'h1);
    step(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
    idle(4);
    chk("reset_no_stale", 64'(n_pops - p0), 64'd0);

    // Random traffic with occasional hold and flush.
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(3) != 0), 1'($urandom_range(1)), rnd_opnd(), rnd_opnd(),
           ($urandom_range(6) == 0), ($urandom_range(24) == 0), 1'b1);
    end
    idle(STAGES + 2);
    chk("drain_empty", 64'(q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
